// File: rtl/uart_pkg.sv
// Shared types and constants for the UART result-word serializer.
// Build option UART_DOUT_HDR_EN selects 4-byte frames with a sequence header.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, HDR, BYTE_L, BYTE_M, BYTE_H} dout_fsm_t;

  localparam logic [3:0] UART_DOUT_HDR_TAG = 4'hA;

`ifdef UART_DOUT_HDR_EN
  localparam int UART_DOUT_FRAME_LEN = 4;
`else
  localparam int UART_DOUT_FRAME_LEN = 3;
`endif

endpackage

// File: rtl/uart_dout_fifo.sv
// Result-word buffer: synchronous FIFO, head word presented on rdata while non-empty.
// Status flags come straight from the pointer flops, so a pop frees space one cycle later.
module uart_dout_fifo #(
  parameter int DATA_W     = 21,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_dout_serializer.sv
// Buffers algorithm result words and sends each as a byte frame L, M, H to the UART TX FIFO.
// UART_DOUT_HDR_EN prepends a header byte {A, seq} to every frame.
//
// state  | meaning
// IDLE   | no frame in progress, pop head word when buffer non-empty
// HDR    | sending header byte {tag, seq} (UART_DOUT_HDR_EN only)
// BYTE_L | sending data[7:0]
// BYTE_M | sending data[15:8]
// BYTE_H | sending zero-padded data[DATA_W-1:16]; pop next word for back-to-back frames
module uart_dout_serializer
  import uart_pkg::*;
#(
  parameter int DATA_W     = 21,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cr_en,
  input  logic              cr_rst,
  input  logic [DATA_W-1:0] dout_data,
  input  logic              dout_vld,
  output logic              dout_rdy,
  output logic [7:0]        tx_data,
  output logic              tx_vld,
  input  logic              tx_rdy,
  output logic              buf_empty,
  output logic              buf_full,
  output logic              busy,
  output logic              frame_done
);

  logic              flush;
  logic              pop;
  logic [DATA_W-1:0] head;
  dout_fsm_t         state_q, state_d;
  logic [23:0]       sh_q, sh_d;

`ifdef UART_DOUT_HDR_EN
  localparam dout_fsm_t FIRST = HDR;
  logic [3:0] seq_q, seq_d;
`else
  localparam dout_fsm_t FIRST = BYTE_L;
`endif

  assign flush    = rst || cr_rst;
  assign dout_rdy = cr_en && !flush && !buf_full;

  uart_dout_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (dout_vld && dout_rdy),
    .pop   (pop),
    .flush (cr_rst),
    .wdata (dout_data),
    .rdata (head),
    .empty (buf_empty),
    .full  (buf_full)
  );

  always_ff @(posedge clk) begin
    if (flush) begin
      state_q <= IDLE;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
    end
  end

  // The shift register always presents the current byte in its low 8 bits.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!buf_empty) begin
          pop     = 1'b1;
          sh_d    = 24'(head);
          state_d = FIRST;
        end
      end
`ifdef UART_DOUT_HDR_EN
      HDR: begin
        if (tx_rdy) state_d = BYTE_L;
      end
`endif
      BYTE_L: begin
        if (tx_rdy) begin
          sh_d    = sh_q >> 8;
          state_d = BYTE_M;
        end
      end
      BYTE_M: begin
        if (tx_rdy) begin
          sh_d    = sh_q >> 8;
          state_d = BYTE_H;
        end
      end
      BYTE_H: begin
        if (tx_rdy) begin
          if (!buf_empty) begin
            pop     = 1'b1;
            sh_d    = 24'(head);
            state_d = FIRST;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are suppressed during a flush so an aborted frame leaks no extra byte.
  always_comb begin
    tx_vld     = 1'b0;
    tx_data    = 8'h00;
    frame_done = 1'b0;
    busy       = (state_q != IDLE);
    if (!flush) begin
      case (state_q)
`ifdef UART_DOUT_HDR_EN
        HDR: begin
          tx_vld  = 1'b1;
          tx_data = {UART_DOUT_HDR_TAG, seq_q};
        end
`endif
        BYTE_L, BYTE_M: begin
          tx_vld  = 1'b1;
          tx_data = sh_q[7:0];
        end
        BYTE_H: begin
          tx_vld     = 1'b1;
          tx_data    = sh_q[7:0];
          frame_done = tx_rdy;
        end
        default: ;
      endcase
    end
  end

`ifdef UART_DOUT_HDR_EN
  always_comb begin
    seq_d = frame_done ? seq_q + 4'd1 : seq_q;
  end

  always_ff @(posedge clk) begin
    if (flush) seq_q <= 4'd0;
    else       seq_q <= seq_d;
  end
`endif

endmodule

// File: tb/tb_uart_dout_serializer.sv
// Self-checking bench for uart_dout_serializer: directed scenarios plus a randomized
// run scored against a byte-queue model of the frame format.
module tb_uart_dout_serializer;
  import uart_pkg::*;

  localparam int DATA_W     = 21;
  localparam int FIFO_DEPTH = 2;
`ifdef UART_DOUT_HDR_EN
  localparam int HDR_N = 1;
`else
  localparam int HDR_N = 0;
`endif
  localparam int FL = UART_DOUT_FRAME_LEN;

  logic              clk;
  logic              rst;
  logic              cr_en;
  logic              cr_rst;
  logic [DATA_W-1:0] dout_data;
  logic              dout_vld;
  logic              dout_rdy;
  logic [7:0]        tx_data;
  logic              tx_vld;
  logic              tx_rdy;
  logic              buf_empty;
  logic              buf_full;
  logic              busy;
  logic              frame_done;

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_dout_serializer #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cr_en      (cr_en),
    .cr_rst     (cr_rst),
    .dout_data  (dout_data),
    .dout_vld   (dout_vld),
    .dout_rdy   (dout_rdy),
    .tx_data    (tx_data),
    .tx_vld     (tx_vld),
    .tx_rdy     (tx_rdy),
    .buf_empty  (buf_empty),
    .buf_full   (buf_full),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Byte idx of the frame for word w sent with header sequence number seq.
  function automatic logic [7:0] exp_byte(input logic [DATA_W-1:0] w, input int seq, input int idx);
    int k;
    if (HDR_N == 1 && idx == 0) return 8'hA0 | 8'(seq % 16);
    k = idx - HDR_N;
    return 8'((int'(w) >> (8 * k)) & 255);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cr_rst = 1'b0; cr_en = 1'b1; dout_vld = 1'b0; tx_rdy = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; dout_vld = 1'b1; dout_data = 21'h155AA; cr_en = 1'b1; tx_rdy = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (dout_rdy !== 1'b0) begin n_err++; $display("FAIL reset_dout_rdy: got %b expected 0", dout_rdy); end
    n_cmp++; if (tx_vld !== 1'b0 || tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx: got vld=%b data=%h expected 0/00", tx_vld, tx_data); end
    n_cmp++; if (buf_empty !== 1'b1 || buf_full !== 1'b0) begin n_err++; $display("FAIL reset_buf: got empty=%b full=%b expected 1/0", buf_empty, buf_full); end
    n_cmp++; if (busy !== 1'b0 || frame_done !== 1'b0) begin n_err++; $display("FAIL reset_busy: got busy=%b done=%b expected 0/0", busy, frame_done); end
    @(negedge clk);
    rst = 1'b0; dout_vld = 1'b0;
    #1;
    n_cmp++; if (buf_empty !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL reset_after: got empty=%b busy=%b expected 1/0", buf_empty, busy); end
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] w;
    w = 21'h1A2B3C;
    do_reset();
    @(negedge clk);
    dout_vld = 1'b1; dout_data = w; tx_rdy = 1'b1; #1;
    n_cmp++; if (dout_rdy !== 1'b1) begin n_err++; $display("FAIL single_accept: got %b expected 1", dout_rdy); end
    @(negedge clk);
    dout_vld = 1'b0; #1;
    n_cmp++; if (tx_vld !== 1'b0) begin n_err++; $display("FAIL single_gap: got tx_vld=%b expected 0", tx_vld); end
    for (int i = 0; i < FL; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (tx_vld !== 1'b1 || tx_data !== exp_byte(w, 0, i) || frame_done !== (i == FL - 1)) begin
        n_err++;
        $display("FAIL single_byte%0d: got vld=%b data=%h done=%b expected 1/%h/%b",
                 i, tx_vld, tx_data, frame_done, exp_byte(w, 0, i), (i == FL - 1));
      end
    end
    @(negedge clk); #1;
    n_cmp++; if (tx_vld !== 1'b0 || busy !== 1'b0 || buf_empty !== 1'b1) begin n_err++; $display("FAIL single_end: got vld=%b busy=%b empty=%b expected 0/0/1", tx_vld, busy, buf_empty); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] w [4];
    int acc_cyc [4];
    logic [7:0] got [$];
    int nacc, first, last;
    for (int i = 0; i < 4; i++) w[i] = DATA_W'($urandom);
    nacc = 0; first = -1; last = -1;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      dout_vld = (nacc < 4); dout_data = w[(nacc < 4) ? nacc : 0]; tx_rdy = 1'b1; #1;
      if (c == 3) begin
        n_cmp++; if (buf_full !== 1'b1) begin n_err++; $display("FAIL b2b_full_c3: got %b expected 1", buf_full); end
      end
      if (buf_full === 1'b1) begin
        n_cmp++; if (dout_rdy !== 1'b0) begin n_err++; $display("FAIL b2b_rdy_when_full: got %b expected 0 at cycle %0d", dout_rdy, c); end
      end
      if (tx_vld === 1'b1) begin
        got.push_back(tx_data);
        if (first < 0) first = c;
        last = c;
      end
      if (dout_vld && dout_rdy === 1'b1) begin acc_cyc[nacc] = c; nacc++; end
    end
    dout_vld = 1'b0;
    n_cmp++; if (nacc != 4) begin n_err++; $display("FAIL b2b_accepts: got %0d expected 4", nacc); end
    else begin
      n_cmp++;
      if (acc_cyc[0] != 0 || acc_cyc[1] != 1 || acc_cyc[2] != 2 || acc_cyc[3] != 2 + FL) begin
        n_err++;
        $display("FAIL b2b_accept_cycles: got %0d,%0d,%0d,%0d expected 0,1,2,%0d", acc_cyc[0], acc_cyc[1], acc_cyc[2], acc_cyc[3], 2 + FL);
      end
    end
    n_cmp++;
    if (got.size() != 4 * FL || first != 2 || last - first + 1 != 4 * FL) begin
      n_err++;
      $display("FAIL b2b_stream: got %0d bytes cycles %0d..%0d expected %0d bytes cycles 2..%0d", got.size(), first, last, 4 * FL, 1 + 4 * FL);
    end else begin
      for (int f = 0; f < 4; f++)
        for (int i = 0; i < FL; i++) begin
          n_cmp++;
          if (got[f * FL + i] !== exp_byte(w[f], f, i)) begin
            n_err++;
            $display("FAIL b2b_byte f%0d b%0d: got %h expected %h", f, i, got[f * FL + i], exp_byte(w[f], f, i));
          end
        end
    end
  endtask

  task automatic test_stall();
    logic [DATA_W-1:0] w;
    logic pat [4];
    logic [7:0] got [$];
    logic prev_stall;
    logic [7:0] prev_data;
    int ndone;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    w = DATA_W'($urandom);
    prev_stall = 1'b0; prev_data = 8'h00; ndone = 0;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      dout_vld = (c == 0); dout_data = w;
      tx_rdy = (c >= 2 && c < 6) ? pat[c - 2] : 1'b1;
      #1;
      if (prev_stall) begin
        n_cmp++;
        if (tx_vld !== 1'b1 || tx_data !== prev_data) begin
          n_err++; $display("FAIL stall_hold: got vld=%b data=%h expected 1/%h", tx_vld, tx_data, prev_data);
        end
      end
      if (tx_vld === 1'b1 && tx_rdy) got.push_back(tx_data);
      if (frame_done === 1'b1) ndone++;
      prev_stall = (tx_vld === 1'b1) && !tx_rdy;
      prev_data  = tx_data;
    end
    n_cmp++;
    if (got.size() != FL || ndone != 1) begin
      n_err++; $display("FAIL stall_count: got %0d bytes %0d done expected %0d/1", got.size(), ndone, FL);
    end else begin
      for (int i = 0; i < FL; i++) begin
        n_cmp++;
        if (got[i] !== exp_byte(w, 0, i)) begin n_err++; $display("FAIL stall_byte%0d: got %h expected %h", i, got[i], exp_byte(w, 0, i)); end
      end
    end
  endtask

  task automatic test_cr_rst();
    logic [DATA_W-1:0] w0, w1, w2;
    logic [7:0] got [$];
    int rst_cyc, ndone;
    w0 = 21'h0F00FF; w1 = DATA_W'($urandom); w2 = DATA_W'($urandom);
    rst_cyc = 1000;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      cr_rst = (c == rst_cyc); dout_vld = (c < 2); dout_data = (c == 0) ? w0 : w1; tx_rdy = 1'b1; #1;
      if (c == rst_cyc) begin
        n_cmp++; if (dout_rdy !== 1'b0) begin n_err++; $display("FAIL crrst_rdy: got %b expected 0", dout_rdy); end
      end
      if (tx_vld === 1'b1 && tx_rdy) begin
        got.push_back(tx_data);
        if (got.size() == HDR_N + 1) rst_cyc = c + 1;
      end
    end
    cr_rst = 1'b0;
    n_cmp++;
    if (got.size() != HDR_N + 1) begin
      n_err++; $display("FAIL crrst_abort: got %0d bytes expected %0d", got.size(), HDR_N + 1);
    end else begin
      for (int i = 0; i <= HDR_N; i++) begin
        n_cmp++;
        if (got[i] !== exp_byte(w0, 0, i)) begin n_err++; $display("FAIL crrst_byte%0d: got %h expected %h", i, got[i], exp_byte(w0, 0, i)); end
      end
    end
    n_cmp++; if (buf_empty !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL crrst_flushed: got empty=%b busy=%b expected 1/0", buf_empty, busy); end
    got.delete(); ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      dout_vld = (c == 0); dout_data = w2; #1;
      if (tx_vld === 1'b1 && tx_rdy) got.push_back(tx_data);
      if (frame_done === 1'b1) ndone++;
    end
    n_cmp++;
    if (got.size() != FL || ndone != 1) begin
      n_err++; $display("FAIL crrst_next_count: got %0d bytes %0d done expected %0d/1", got.size(), ndone, FL);
    end else begin
      for (int i = 0; i < FL; i++) begin
        n_cmp++;
        if (got[i] !== exp_byte(w2, 0, i)) begin n_err++; $display("FAIL crrst_next_byte%0d: got %h expected %h", i, got[i], exp_byte(w2, 0, i)); end
      end
    end
  endtask

  task automatic test_cr_en();
    logic [DATA_W-1:0] w0, w1, w2;
    logic [7:0] got [$];
    w0 = DATA_W'($urandom); w1 = DATA_W'($urandom); w2 = DATA_W'($urandom);
    do_reset();
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      cr_en = (c < 3); dout_vld = 1'b1; dout_data = (c == 0) ? w0 : (c == 1) ? w1 : w2; tx_rdy = 1'b1; #1;
      if (c >= 3) begin
        n_cmp++; if (dout_rdy !== 1'b0) begin n_err++; $display("FAIL cren_rdy: got %b expected 0 at cycle %0d", dout_rdy, c); end
      end
      if (c == 2) dout_vld = 1'b0;
      if (tx_vld === 1'b1 && tx_rdy) got.push_back(tx_data);
    end
    dout_vld = 1'b0; cr_en = 1'b1;
    n_cmp++;
    if (got.size() != 2 * FL) begin
      n_err++; $display("FAIL cren_count: got %0d bytes expected %0d", got.size(), 2 * FL);
    end else begin
      for (int i = 0; i < FL; i++) begin
        n_cmp++;
        if (got[i] !== exp_byte(w0, 0, i) || got[FL + i] !== exp_byte(w1, 1, i)) begin
          n_err++; $display("FAIL cren_byte%0d: got %h/%h expected %h/%h", i, got[i], got[FL + i], exp_byte(w0, 0, i), exp_byte(w1, 1, i));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [8:0] exp_q [$];
    logic [8:0] e;
    logic prev_stall;
    logic [7:0] prev_data;
    int mseq;
    do_reset();
    mseq = 0; prev_stall = 1'b0; prev_data = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c < 2700) begin
        dout_vld  = 1'($urandom_range(0, 1));
        dout_data = DATA_W'($urandom);
        cr_en     = ($urandom_range(0, 7) != 0);
        tx_rdy    = ($urandom_range(0, 3) != 0);
      end else begin
        dout_vld = 1'b0; cr_en = 1'b1; tx_rdy = 1'b1;
      end
      #1;
      if (!cr_en) begin
        n_cmp++; if (dout_rdy !== 1'b0) begin n_err++; $display("FAIL rand_rdy_disabled: got %b expected 0", dout_rdy); end
      end
      if (prev_stall) begin
        n_cmp++;
        if (tx_vld !== 1'b1 || tx_data !== prev_data) begin n_err++; $display("FAIL rand_hold: got vld=%b data=%h expected 1/%h", tx_vld, tx_data, prev_data); end
      end
      if (tx_vld === 1'b1 && tx_rdy) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_extra_byte: got %h expected none", tx_data);
        end else begin
          e = exp_q.pop_front();
          if ({frame_done, tx_data} !== e) begin n_err++; $display("FAIL rand_byte: got done=%b data=%h expected %b/%h", frame_done, tx_data, e[8], e[7:0]); end
        end
      end
      prev_stall = (tx_vld === 1'b1) && !tx_rdy;
      prev_data  = tx_data;
      if (dout_vld && dout_rdy === 1'b1) begin
        for (int i = 0; i < FL; i++) begin
          e = {(i == FL - 1), exp_byte(dout_data, mseq, i)};
          exp_q.push_back(e);
        end
        mseq++;
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_drain: got %0d bytes outstanding expected 0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1; cr_en = 1'b1; cr_rst = 1'b0; dout_vld = 1'b0; dout_data = '0; tx_rdy = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_cr_rst();
    test_cr_en();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
